// File: rtl/rv_iommu_walk_tracker.sv
// IOMMU page-walk tracker: accepts translation requests, issues walks, collects out-of-order completions, returns responses.
// Optional build macro IOMMU_PWT_INORDER_RSP_EN returns responses in acceptance order via an age FIFO.
module rv_iommu_walk_tracker #(
  parameter int MAX_PW = 4,
  parameter int IOVA_W = 52,
  parameter int TAG_W  = 8,
  parameter int PPN_W  = 34,
  localparam int IDX_W = $clog2(MAX_PW)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IOVA_W-1:0]   atr_iova,
  input  logic [23:0]         atr_device_id,
  input  logic [19:0]         atr_process_id,
  input  logic [5:0]          atr_ctl,
  input  logic [TAG_W-1:0]    atr_tag,
  input  logic                atr_irdy,
  output logic                atr_trdy,
  output logic                wke_valid,
  input  logic                wke_ready,
  output logic [IDX_W-1:0]    wke_idx,
  output logic [IOVA_W+49:0]  wke_req,
  input  logic                wkc_valid,
  input  logic [IDX_W-1:0]    wkc_idx,
  input  logic [2:0]          wkc_status,
  input  logic [PPN_W-1:0]    wkc_ppn,
  input  logic [6:0]          wkc_attr,
  output logic                atc_irdy,
  input  logic                atc_trdy,
  output logic [2:0]          atc_status,
  output logic [PPN_W-1:0]    atc_resp_pa,
  output logic [TAG_W-1:0]    atc_tag,
  output logic [6:0]          atc_attr,
  input  logic                ddtp_pgwk_stall_req_i,
  output logic                ddtp_pgwk_idle_o,
  output logic                wkc_err_o
);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_WALK, ST_DONE} ent_state_e;

  ent_state_e state_reg  [MAX_PW];
  ent_state_e state_next [MAX_PW];

  logic [IOVA_W-1:0] iova_mem   [MAX_PW];
  logic [23:0]       dev_mem    [MAX_PW];
  logic [19:0]       pid_mem    [MAX_PW];
  logic [5:0]        ctl_mem    [MAX_PW];
  logic [TAG_W-1:0]  tag_mem    [MAX_PW];
  logic [2:0]        status_mem [MAX_PW];
  logic [PPN_W-1:0]  ppn_mem    [MAX_PW];
  logic [6:0]        attr_mem   [MAX_PW];

  logic             active_reg;
  logic [CNT_W-1:0] count_reg;
  logic             err_reg;
  logic             iss_valid_reg;
  logic [IDX_W-1:0] iss_idx_reg, iss_ptr_reg;
  logic             rsp_valid_reg;
  logic [IDX_W-1:0] rsp_idx_reg;

  logic [MAX_PW-1:0] free_vec, iss_cand;
  logic [IDX_W-1:0]  alloc_idx, iss_sel, iss_try, rsp_sel;
  logic              acc, iss_found, iss_hs, iss_load, cmp_ok;
  logic              rsp_found, rsp_hs, rsp_load;

  for (genvar gi = 0; gi < MAX_PW; gi++) begin : g_cand
    assign free_vec[gi] = (state_reg[gi] == ST_FREE);
    // The entry sitting in the issue register is still PEND but must not be picked twice.
    assign iss_cand[gi] = (state_reg[gi] == ST_PEND) &&
                          !(iss_valid_reg && (iss_idx_reg == IDX_W'(gi)));
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = MAX_PW - 1; i >= 0; i--)
      if (free_vec[i]) alloc_idx = IDX_W'(i);
  end

  assign atr_trdy = active_reg && (|free_vec) && !ddtp_pgwk_stall_req_i;
  assign acc      = atr_irdy && atr_trdy;
  assign cmp_ok   = wkc_valid && (state_reg[wkc_idx] == ST_WALK);

  always_comb begin
    iss_found = 1'b0;
    iss_sel   = '0;
    iss_try   = '0;
    for (int i = 1; i <= MAX_PW; i++) begin
      iss_try = iss_ptr_reg + IDX_W'(i);
      if (!iss_found && iss_cand[iss_try]) begin
        iss_found = 1'b1;
        iss_sel   = iss_try;
      end
    end
  end

  assign iss_hs   = iss_valid_reg && wke_ready;
  assign iss_load = (!iss_valid_reg || iss_hs) && iss_found;
  assign rsp_hs   = rsp_valid_reg && atc_trdy;
  assign rsp_load = (!rsp_valid_reg || rsp_hs) && rsp_found;

`ifdef IOMMU_PWT_INORDER_RSP_EN
  logic [IDX_W-1:0] age_mem [MAX_PW];
  logic [CNT_W-1:0] age_wr_reg, age_rd_reg;
  logic [IDX_W-1:0] age_head;

  assign age_head  = age_mem[age_rd_reg[IDX_W-1:0]];
  assign rsp_found = (age_wr_reg != age_rd_reg) && (state_reg[age_head] == ST_DONE);
  assign rsp_sel   = age_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_wr_reg <= '0;
      age_rd_reg <= '0;
    end else begin
      if (acc)      age_wr_reg <= age_wr_reg + CNT_W'(1);
      if (rsp_load) age_rd_reg <= age_rd_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (acc) age_mem[age_wr_reg[IDX_W-1:0]] <= alloc_idx;
  end
`else
  logic [MAX_PW-1:0] rsp_cand;
  logic [IDX_W-1:0]  rsp_ptr_reg, rsp_try;

  for (genvar gi = 0; gi < MAX_PW; gi++) begin : g_rsp_cand
    assign rsp_cand[gi] = (state_reg[gi] == ST_DONE) &&
                          !(rsp_valid_reg && (rsp_idx_reg == IDX_W'(gi)));
  end

  always_comb begin
    rsp_found = 1'b0;
    rsp_sel   = '0;
    rsp_try   = '0;
    for (int i = 1; i <= MAX_PW; i++) begin
      rsp_try = rsp_ptr_reg + IDX_W'(i);
      if (!rsp_found && rsp_cand[rsp_try]) begin
        rsp_found = 1'b1;
        rsp_sel   = rsp_try;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rsp_ptr_reg <= '1;
    else if (rsp_load) rsp_ptr_reg <= rsp_sel;
  end
`endif

  // Each event targets an entry in a distinct state, so these writes never collide.
  always_comb begin
    for (int i = 0; i < MAX_PW; i++) state_next[i] = state_reg[i];
    if (acc)    state_next[alloc_idx]   = ST_PEND;
    if (iss_hs) state_next[iss_idx_reg] = ST_WALK;
    if (cmp_ok) state_next[wkc_idx]     = ST_DONE;
    if (rsp_hs) state_next[rsp_idx_reg] = ST_FREE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_PW; i++) state_reg[i] <= ST_FREE;
      active_reg    <= 1'b0;
      count_reg     <= '0;
      err_reg       <= 1'b0;
      iss_valid_reg <= 1'b0;
      iss_idx_reg   <= '0;
      iss_ptr_reg   <= '1;
      rsp_valid_reg <= 1'b0;
      rsp_idx_reg   <= '0;
    end else begin
      for (int i = 0; i < MAX_PW; i++) state_reg[i] <= state_next[i];
      active_reg <= 1'b1;
      err_reg    <= wkc_valid && !cmp_ok;
      if (acc && !rsp_hs)      count_reg <= count_reg + CNT_W'(1);
      else if (!acc && rsp_hs) count_reg <= count_reg - CNT_W'(1);
      if (iss_load) begin
        iss_valid_reg <= 1'b1;
        iss_idx_reg   <= iss_sel;
        iss_ptr_reg   <= iss_sel;
      end else if (iss_hs) begin
        iss_valid_reg <= 1'b0;
      end
      if (rsp_load) begin
        rsp_valid_reg <= 1'b1;
        rsp_idx_reg   <= rsp_sel;
      end else if (rsp_hs) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      iova_mem[alloc_idx] <= atr_iova;
      dev_mem[alloc_idx]  <= atr_device_id;
      pid_mem[alloc_idx]  <= atr_process_id;
      ctl_mem[alloc_idx]  <= atr_ctl;
      tag_mem[alloc_idx]  <= atr_tag;
    end
    if (cmp_ok) begin
      status_mem[wkc_idx] <= wkc_status;
      ppn_mem[wkc_idx]    <= wkc_ppn;
      attr_mem[wkc_idx]   <= wkc_attr;
    end
  end

  assign wke_valid   = iss_valid_reg;
  assign wke_idx     = iss_idx_reg;
  assign wke_req     = iss_valid_reg ? {iova_mem[iss_idx_reg], dev_mem[iss_idx_reg],
                                        pid_mem[iss_idx_reg], ctl_mem[iss_idx_reg]} : '0;
  assign atc_irdy    = rsp_valid_reg;
  assign atc_status  = rsp_valid_reg ? status_mem[rsp_idx_reg] : '0;
  assign atc_resp_pa = rsp_valid_reg ? ppn_mem[rsp_idx_reg]    : '0;
  assign atc_tag     = rsp_valid_reg ? tag_mem[rsp_idx_reg]    : '0;
  assign atc_attr    = rsp_valid_reg ? attr_mem[rsp_idx_reg]   : '0;

  assign ddtp_pgwk_idle_o = (count_reg == '0);
  assign wkc_err_o        = err_reg;
endmodule

// File: tb/tb_rv_iommu_walk_tracker.sv
// Directed self-checking bench for rv_iommu_walk_tracker (MAX_PW=4); honours IOMMU_PWT_INORDER_RSP_EN.
module tb_rv_iommu_walk_tracker;
  localparam int MAX_PW = 4;
  localparam int IOVA_W = 52;
  localparam int TAG_W  = 8;
  localparam int PPN_W  = 34;
  localparam int IDX_W  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [IOVA_W-1:0]  atr_iova = '0;
  logic [23:0]        atr_device_id = '0;
  logic [19:0]        atr_process_id = '0;
  logic [5:0]         atr_ctl = '0;
  logic [TAG_W-1:0]   atr_tag = '0;
  logic               atr_irdy = 1'b0;
  logic               atr_trdy;
  logic               wke_valid;
  logic               wke_ready = 1'b0;
  logic [IDX_W-1:0]   wke_idx;
  logic [IOVA_W+49:0] wke_req;
  logic               wkc_valid = 1'b0;
  logic [IDX_W-1:0]   wkc_idx = '0;
  logic [2:0]         wkc_status = '0;
  logic [PPN_W-1:0]   wkc_ppn = '0;
  logic [6:0]         wkc_attr = '0;
  logic               atc_irdy;
  logic               atc_trdy = 1'b0;
  logic [2:0]         atc_status;
  logic [PPN_W-1:0]   atc_resp_pa;
  logic [TAG_W-1:0]   atc_tag;
  logic [6:0]         atc_attr;
  logic               stall = 1'b0;
  logic               idle;
  logic               wkc_err;

  int n_cmp = 0;
  int n_err = 0;

  rv_iommu_walk_tracker #(.MAX_PW(MAX_PW), .IOVA_W(IOVA_W), .TAG_W(TAG_W), .PPN_W(PPN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .atr_iova(atr_iova), .atr_device_id(atr_device_id), .atr_process_id(atr_process_id),
    .atr_ctl(atr_ctl), .atr_tag(atr_tag), .atr_irdy(atr_irdy), .atr_trdy(atr_trdy),
    .wke_valid(wke_valid), .wke_ready(wke_ready), .wke_idx(wke_idx), .wke_req(wke_req),
    .wkc_valid(wkc_valid), .wkc_idx(wkc_idx), .wkc_status(wkc_status), .wkc_ppn(wkc_ppn),
    .wkc_attr(wkc_attr),
    .atc_irdy(atc_irdy), .atc_trdy(atc_trdy), .atc_status(atc_status),
    .atc_resp_pa(atc_resp_pa), .atc_tag(atc_tag), .atc_attr(atc_attr),
    .ddtp_pgwk_stall_req_i(stall), .ddtp_pgwk_idle_o(idle), .wkc_err_o(wkc_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and waits (bounded) for it to be accepted.
  task automatic send_req(input logic [IOVA_W-1:0] iova, input logic [TAG_W-1:0] tag);
    bit ok = 1'b0;
    atr_iova       = iova;
    atr_tag        = tag;
    atr_device_id  = 24'hABC000 | {16'h0, tag};
    atr_process_id = 20'h00100 | {12'h0, tag};
    atr_ctl        = 6'h21;
    atr_irdy       = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (atr_trdy) begin ok = 1'b1; break; end
      cyc();
    end
    cyc();
    atr_irdy = 1'b0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL send_req_timeout tag=%0h trdy never seen", tag); end
    $display("req tag=%02h iova=%0h accepted=%0d", tag, iova, ok);
  endtask

  task automatic complete(input int idx, input logic [2:0] st, input logic [PPN_W-1:0] ppn,
                          input logic [6:0] attr);
    wkc_valid = 1'b1; wkc_idx = IDX_W'(idx); wkc_status = st; wkc_ppn = ppn; wkc_attr = attr;
    cyc();
    wkc_valid = 1'b0;
    $display("cmp idx=%0d status=%0d ppn=%0h", idx, st, ppn);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    n_cmp++; if (atr_trdy !== 1'b0) begin n_err++; $display("FAIL rst_trdy got=%b exp=0", atr_trdy); end
    n_cmp++; if (wke_valid !== 1'b0) begin n_err++; $display("FAIL rst_wke_valid got=%b exp=0", wke_valid); end
    n_cmp++; if (atc_irdy !== 1'b0) begin n_err++; $display("FAIL rst_atc_irdy got=%b exp=0", atc_irdy); end
    n_cmp++; if (wkc_err !== 1'b0) begin n_err++; $display("FAIL rst_wkc_err got=%b exp=0", wkc_err); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle got=%b exp=1", idle); end
    n_cmp++; if (wke_req !== '0 || atc_tag !== '0 || atc_resp_pa !== '0)
      begin n_err++; $display("FAIL rst_data req=%0h tag=%0h pa=%0h exp=0", wke_req, atc_tag, atc_resp_pa); end
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (atr_trdy !== 1'b1) begin n_err++; $display("FAIL post_rst_trdy got=%b exp=1", atr_trdy); end
    $display("reset done trdy=%b idle=%b", atr_trdy, idle);
  endtask

  task automatic test_single();
    logic [IOVA_W+49:0] exp_req;
    exp_req = {52'h1000, 24'hABC05A, 20'h0015A, 6'h21};
    wke_ready = 1'b1; atc_trdy = 1'b0;
    send_req(52'h1000, 8'h5A);
    n_cmp++; if (wke_valid !== 1'b0) begin n_err++; $display("FAIL single_wke_early got=%b exp=0", wke_valid); end
    n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got=%b exp=0", idle); end
    cyc();
    n_cmp++; if (wke_valid !== 1'b1 || wke_idx !== 2'd0)
      begin n_err++; $display("FAIL single_issue valid=%b idx=%0d exp valid=1 idx=0", wke_valid, wke_idx); end
    n_cmp++; if (wke_req !== exp_req) begin n_err++; $display("FAIL single_wke_req got=%0h exp=%0h", wke_req, exp_req); end
    cyc();
    n_cmp++; if (wke_valid !== 1'b0) begin n_err++; $display("FAIL single_wke_drop got=%b exp=0", wke_valid); end
    complete(0, 3'd0, 34'h123, 7'h45);
    n_cmp++; if (atc_irdy !== 1'b0) begin n_err++; $display("FAIL single_atc_early got=%b exp=0", atc_irdy); end
    cyc();
    n_cmp++; if (atc_irdy !== 1'b1 || atc_tag !== 8'h5A || atc_resp_pa !== 34'h123)
      begin n_err++; $display("FAIL single_rsp irdy=%b tag=%0h pa=%0h exp 1/5a/123", atc_irdy, atc_tag, atc_resp_pa); end
    n_cmp++; if (atc_attr !== 7'h45 || atc_status !== 3'd0 || wkc_err !== 1'b0)
      begin n_err++; $display("FAIL single_rsp_attr attr=%0h st=%0d err=%b exp 45/0/0", atc_attr, atc_status, wkc_err); end
    cyc();
    n_cmp++; if (atc_irdy !== 1'b1 || atc_tag !== 8'h5A)
      begin n_err++; $display("FAIL single_rsp_hold irdy=%b tag=%0h exp 1/5a", atc_irdy, atc_tag); end
    atc_trdy = 1'b1;
    cyc();
    atc_trdy = 1'b0;
    n_cmp++; if (atc_irdy !== 1'b0 || idle !== 1'b1)
      begin n_err++; $display("FAIL single_done irdy=%b idle=%b exp 0/1", atc_irdy, idle); end
    $display("single txn tag=5a complete");
  endtask

  task automatic test_full_out_of_order();
    int ord[4] = '{3, 1, 0, 2};
    int exp_rsp[4];
    int got;
    bit hs;
    logic [TAG_W-1:0] t;
    logic [PPN_W-1:0] pa;
    logic [IDX_W-1:0] ix;
`ifdef IOMMU_PWT_INORDER_RSP_EN
    exp_rsp = '{0, 1, 2, 3};
`else
    exp_rsp = '{3, 1, 0, 2};
`endif
    wke_ready = 1'b0; atc_trdy = 1'b0;
    for (int i = 0; i < 4; i++) send_req(52'h2000 + IOVA_W'(i), 8'h10 + TAG_W'(i));
    atr_irdy = 1'b1; atr_tag = 8'h99;
    n_cmp++; if (atr_trdy !== 1'b0) begin n_err++; $display("FAIL full_trdy got=%b exp=0", atr_trdy); end
    n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL full_idle got=%b exp=0", idle); end
    cyc(); cyc();
    n_cmp++; if (atr_trdy !== 1'b0 || wke_valid !== 1'b1 || wke_idx !== 2'd0)
      begin n_err++; $display("FAIL full_hold trdy=%b wv=%b idx=%0d exp 0/1/0", atr_trdy, wke_valid, wke_idx); end
    atr_irdy = 1'b0;
    wke_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk); hs = wke_valid && wke_ready; ix = wke_idx;
      cyc();
      if (hs) begin
        n_cmp++; if (ix !== IDX_W'(got)) begin n_err++; $display("FAIL issue_order[%0d] got=%0d exp=%0d", got, ix, got); end
        $display("issue idx=%0d", ix);
        got++;
      end
    end
    n_cmp++; if (got != 4) begin n_err++; $display("FAIL issue_timeout got=%0d exp=4", got); end
    atc_trdy = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (c < 4) begin
        wkc_valid = 1'b1; wkc_idx = IDX_W'(ord[c]); wkc_status = 3'(ord[c]);
        wkc_ppn = 34'h100 + PPN_W'(ord[c]); wkc_attr = 7'h10 + 7'(ord[c]);
      end else begin
        wkc_valid = 1'b0;
      end
      @(negedge clk); hs = atc_irdy && atc_trdy; t = atc_tag; pa = atc_resp_pa;
      cyc();
      if (hs) begin
        n_cmp++; if (t !== 8'h10 + TAG_W'(exp_rsp[got]) || pa !== 34'h100 + PPN_W'(exp_rsp[got]))
          begin n_err++; $display("FAIL rsp_order[%0d] tag=%0h pa=%0h exp entry %0d", got, t, pa, exp_rsp[got]); end
        if (got == 0) begin
          n_cmp++; if (atr_trdy !== 1'b1) begin n_err++; $display("FAIL free_one_trdy got=%b exp=1", atr_trdy); end
        end
        $display("rsp tag=%02h pa=%0h", t, pa);
        got++;
      end
    end
    wkc_valid = 1'b0; atc_trdy = 1'b0;
    n_cmp++; if (got != 4) begin n_err++; $display("FAIL rsp_timeout got=%0d exp=4", got); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL ooo_idle got=%b exp=1", idle); end
  endtask

  task automatic test_stall();
    int got;
    bit hs;
    logic [TAG_W-1:0] t;
    wke_ready = 1'b1; atc_trdy = 1'b0;
    send_req(52'h3000, 8'h20);
    send_req(52'h3001, 8'h21);
    stall = 1'b1; atr_irdy = 1'b1; atr_tag = 8'hEE;
    #1;
    n_cmp++; if (atr_trdy !== 1'b0) begin n_err++; $display("FAIL stall_trdy got=%b exp=0", atr_trdy); end
    repeat (4) cyc();
    complete(0, 3'd1, 34'h200, 7'h01);
    complete(1, 3'd2, 34'h201, 7'h02);
    atc_trdy = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk); hs = atc_irdy && atc_trdy; t = atc_tag;
      n_cmp++; if (atr_trdy !== 1'b0) begin n_err++; $display("FAIL stall_drain_trdy got=%b exp=0", atr_trdy); end
      cyc();
      if (hs) begin
        n_cmp++; if (t !== 8'h20 + TAG_W'(got)) begin n_err++; $display("FAIL stall_rsp[%0d] got=%0h exp=%0h", got, t, 8'h20 + got); end
        $display("stall rsp tag=%02h", t);
        got++;
      end
    end
    n_cmp++; if (got != 2 || idle !== 1'b1)
      begin n_err++; $display("FAIL stall_idle got_rsp=%0d idle=%b exp 2/1", got, idle); end
    atr_irdy = 1'b0; stall = 1'b0; atc_trdy = 1'b0;
  endtask

  task automatic test_bad_completion();
    complete(2, 3'd5, 34'h3FF, 7'h7F);
    n_cmp++; if (wkc_err !== 1'b1) begin n_err++; $display("FAIL err_pulse got=%b exp=1", wkc_err); end
    cyc();
    n_cmp++; if (wkc_err !== 1'b0) begin n_err++; $display("FAIL err_one_cycle got=%b exp=0", wkc_err); end
    n_cmp++; if (atc_irdy !== 1'b0 || idle !== 1'b1)
      begin n_err++; $display("FAIL err_no_rsp irdy=%b idle=%b exp 0/1", atc_irdy, idle); end
    $display("bad completion idx=2 err seen");
  endtask

  task automatic test_reset_midwalk();
    wke_ready = 1'b1; atc_trdy = 1'b0;
    send_req(52'h4000, 8'h30);
    send_req(52'h4001, 8'h31);
    send_req(52'h4002, 8'h32);
    repeat (4) cyc();
    complete(0, 3'd0, 34'h300, 7'h03);
    cyc();
    n_cmp++; if (atc_irdy !== 1'b1) begin n_err++; $display("FAIL midwalk_irdy got=%b exp=1", atc_irdy); end
    wke_ready = 1'b0;
    send_req(52'h4003, 8'h33);
    cyc();
    n_cmp++; if (wke_valid !== 1'b1 || wke_idx !== 2'd3)
      begin n_err++; $display("FAIL midwalk_issue wv=%b idx=%0d exp 1/3", wke_valid, wke_idx); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (atc_irdy !== 1'b0 || wke_valid !== 1'b0)
      begin n_err++; $display("FAIL async_rst_drop irdy=%b wv=%b exp 0/0", atc_irdy, wke_valid); end
    n_cmp++; if (idle !== 1'b1 || atr_trdy !== 1'b0 || atc_tag !== '0)
      begin n_err++; $display("FAIL async_rst_state idle=%b trdy=%b tag=%0h exp 1/0/0", idle, atr_trdy, atc_tag); end
    cyc();
    rst_n = 1'b1;
    wke_ready = 1'b1;
    send_req(52'h7700, 8'h77);
    n_cmp++; if (wke_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_early got=%b exp=0", wke_valid); end
    cyc();
    n_cmp++; if (wke_valid !== 1'b1 || wke_idx !== 2'd0)
      begin n_err++; $display("FAIL post_rst_alloc wv=%b idx=%0d exp 1/0", wke_valid, wke_idx); end
    complete(1, 3'd0, 34'h1, 7'h0);
    n_cmp++; if (wkc_err !== 1'b1) begin n_err++; $display("FAIL stale_cmp_err got=%b exp=1", wkc_err); end
    $display("reset mid-walk recovered");
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_out_of_order();
    test_stall();
    test_bad_completion();
    test_reset_midwalk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
